sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, fully parametrised successor to the team's dual-clock FIFO.
- Adds configurable data width and depth, occupancy count, programmable almost-full and almost-empty thresholds, synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between same-clock producer/consumer stages; keeps the existing wr/rd/valid/overflow/underflow handshake so existing benches port directly.

Parameters:
- DATA_WIDTH, 8, width of wdata/rdata.
- DEPTH, 16, number of entries; must be a power of 2 and at least 2.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value.
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.
- ADDR_WIDTH (localparam), $clog2(DEPTH), memory address width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of contents.
- wr  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- rd  in  1  read request (in FWFT mode: pop/acknowledge).
- rdata  out  DATA_WIDTH  read data.
- valid  out  1  rdata qualifier.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: rejected write.
- underflow  out  1  one-cycle pulse: rejected read.

Behaviour:
- Reset (rst_n=0 at edge): pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, valid=0, rdata=0, overflow=0, underflow=0. Reset mid-operation discards contents; memory array is not cleared.
- Priority per edge: rst_n, then flush, then wr/rd.
- Pointers are ADDR_WIDTH+1 bits and wrap naturally; the MSB distinguishes full from empty. count is a registered up/down counter; all flags decode from the registered count.
- Write accept: wr && !full, using full before the edge. Rejected write (wr && full): memory and count unchanged, overflow=1 the next cycle.
- Read accept: rd && !empty, using empty before the edge. Rejected read (rd && empty): underflow=1 the next cycle, valid=0.
- Simultaneous accepted rd and wr: count unchanged. When full, rd is accepted and wr is rejected (overflow). When empty, wr is accepted and rd is rejected (underflow); no bypass of the new word.
- Standard mode (FWFT=0): rdata registers the head word on an accepted read; valid=1 for exactly the following cycle. rdata holds its last value otherwise. Read latency is 1 cycle.
- FWFT mode (FWFT=1): rdata shows the head word combinationally from memory; valid = !empty. An accepted rd pops the head, and the next word appears in the same cycle the count update lands. First write to an empty FIFO is visible with valid=1 one cycle after the write edge.
- flush=1: pointers and count go to 0, flags go to their reset values, valid=0. rdata is retained in standard mode. Any same-cycle wr/rd is ignored and raises no overflow/underflow.
- Threshold flags update in the same cycle as count. Thresholds outside 0..DEPTH simply pin the flag constant.

Decomposition:
- Shared package fifo_pkg: clog2-derived width function, default threshold constants, and FWFT mode encodings (FIFO_STD=0, FIFO_FWFT=1), reused by the dual-clock FIFO generation.
- One sub-module, fifo_mem_2p: DEPTH x DATA_WIDTH register array with synchronous write and asynchronous read. Its read path is registered externally in standard mode.
- Pointer, count, flag and handshake logic live in the top level.

Test Plan:
- Reset: DEPTH=8, hold rst_n=0 for 2 cycles, then release -> empty=1, almost_empty=1, full=0, count=0, valid=0, rdata=0.
- Fill/overflow: write 1..9 back-to-back, DEPTH=8, AFULL_THRESH=6 -> almost_full rises after the 6th write, full and count=8 after the 8th, 9th write gives overflow pulse (1 cycle), count stays 8.
- Drain/underflow, standard mode: 9 consecutive rd -> rdata 1..8 in order, each with a 1-cycle valid pulse one cycle after rd; 9th rd gives underflow pulse, empty=1.
- Simultaneous rd+wr: at count=4, assert both for 3 cycles -> count stays 4; data order preserved across pointer wrap (write 20 words interleaved, read back 1..20).
- Full simultaneous rd+wr: at count=8 -> read accepted, write rejected, overflow=1, count=7.
- FWFT=1: write 0xA5 to empty FIFO -> rdata=0xA5 and valid=1 next cycle with no rd; rd pop -> empty=1, valid=0. flush at count=5 with wr=1 -> count=0, no overflow.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the FIFO family (single-clock and
// dual-clock generations).
//   fifo_clog2     : address width needed to index n entries
//   AEMPTY_DEFAULT : default almost-empty threshold
//   AFULL_MARGIN   : default almost-full threshold is DEPTH - AFULL_MARGIN
//   FIFO_STD/FWFT  : read-mode encodings for the FWFT parameter
package fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   localparam int AEMPTY_DEFAULT = 2;
   localparam int AFULL_MARGIN   = 2;

   function automatic int fifo_clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: DEPTH x DATA_WIDTH register array, one write port and one
// read port. Writes land on the rising edge; reads are combinational, so the
// owner decides whether to register the read path.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (asynchronous)
module fifo_mem_2p #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   // Storage is deliberately not reset.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and selectable
// standard (registered) or first-word-fall-through read.
//   clk, rst_n       : clock, synchronous active-low reset
//   flush            : synchronous clear of contents
//   wr, wdata        : write request and data
//   rd               : read request (pop in FWFT mode)
//   rdata, valid     : read data and its qualifier
//   empty, full      : count == 0 / count == DEPTH
//   almost_empty/full: count <= AEMPTY_THRESH / count >= AFULL_THRESH
//   count            : occupancy 0..DEPTH
//   overflow         : one-cycle pulse after a rejected write
//   underflow        : one-cycle pulse after a rejected read
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - AFULL_MARGIN,
   parameter int AEMPTY_THRESH = AEMPTY_DEFAULT,
   parameter int FWFT          = FIFO_STD,
   localparam int ADDR_WIDTH   = fifo_clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  valid,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, ptr_diff;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] head;

   // Flags come from the registered count only, so they move together.
   assign empty        = (count == '0);
   assign full         = (count == FULL_CNT);
   // int compare lets out-of-range thresholds pin the flag constant.
   assign almost_full  = (int'(count) >= AFULL_THRESH);
   assign almost_empty = (int'(count) <= AEMPTY_THRESH);

   // Acceptance uses pre-edge flags: full rejects wr even if rd frees a slot,
   // empty rejects rd even if wr fills one (no bypass).
   assign wr_acc = wr && !full;
   assign rd_acc = rd && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= wr && full;
         underflow <= rd && empty;
         if (wr_acc) wr_ptr <= wr_ptr + ONE;
         if (rd_acc) rd_ptr <= rd_ptr + ONE;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
      end
   end

   // Extra pointer MSB lets the wrapped pointer distance equal the count,
   // including the full case; any divergence means the bookkeeping broke.
   assign ptr_diff = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (rst_n) assert (ptr_diff == count);
   end

   fifo_mem_2p #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc && rst_n && !flush),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (wdata),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (head)
   );

   generate
      if (FWFT == FIFO_FWFT) begin : g_fwft
         // Head is live off the array; zeroed when empty so stale storage
         // never shows on rdata.
         assign valid = !empty;
         assign rdata = empty ? '0 : head;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] rdata_q;
         logic                  valid_q;

         // rdata holds its last value across idle cycles and flush.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rdata_q <= '0;
               valid_q <= 1'b0;
            end else if (flush) begin
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_acc;
               if (rd_acc) rdata_q <= head;
            end
         end

         assign valid = valid_q;
         assign rdata = rdata_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param. One standard-mode
// instance (DEPTH=8, AFULL=6, AEMPTY=2) checked cycle by cycle against a
// queue scoreboard, and one FWFT instance with directed checks.
module tb_sync_fifo_param;

   localparam int DW = 8;
   localparam int D  = 8;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // standard-mode instance
   logic          s_flush = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
   logic [DW-1:0] s_wdata = '0;
   logic [DW-1:0] s_rdata;
   logic          s_valid, s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
   logic [AW:0]   s_count;

   // FWFT instance
   logic          f_flush = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
   logic [DW-1:0] f_wdata = '0;
   logic [DW-1:0] f_rdata;
   logic          f_valid, f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
   logic [AW:0]   f_count;

   sync_fifo_param #(
      .DATA_WIDTH(DW), .DEPTH(D), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0)
   ) u_std (
      .clk(clk), .rst_n(rst_n), .flush(s_flush), .wr(s_wr), .wdata(s_wdata),
      .rd(s_rd), .rdata(s_rdata), .valid(s_valid), .empty(s_empty),
      .full(s_full), .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
      .overflow(s_ovf), .underflow(s_udf)
   );

   sync_fifo_param #(
      .DATA_WIDTH(DW), .DEPTH(D), .FWFT(1)
   ) u_fwft (
      .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr(f_wr), .wdata(f_wdata),
      .rd(f_rd), .rdata(f_rdata), .valid(f_valid), .empty(f_empty),
      .full(f_full), .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
      .overflow(f_ovf), .underflow(f_udf)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic [DW-1:0] q[$];
   int            mdl_cnt = 0;
   logic [DW-1:0] last_rd = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One clock of the standard instance: predict from pre-edge model state,
   // then compare every output #1 after the edge.
   task automatic tick_std();
      logic          exp_w, exp_r, exp_o, exp_u;
      logic [DW-1:0] exp_d;
      exp_w = s_wr && !s_flush && (mdl_cnt < D);
      exp_r = s_rd && !s_flush && (mdl_cnt > 0);
      exp_o = s_wr && !s_flush && (mdl_cnt == D);
      exp_u = s_rd && !s_flush && (mdl_cnt == 0);
      exp_d = last_rd;
      if (s_flush) begin
         q.delete();
         mdl_cnt = 0;
      end else begin
         if (exp_r) begin
            exp_d = q.pop_front();
            mdl_cnt--;
         end
         if (exp_w) begin
            q.push_back(s_wdata);
            mdl_cnt++;
         end
      end
      last_rd = exp_d;
      @(posedge clk);
      #1;
      check("s_valid", s_valid, exp_r);
      check("s_rdata", s_rdata, exp_d);
      check("s_count", s_count, mdl_cnt);
      check("s_empty", s_empty, mdl_cnt == 0);
      check("s_full", s_full, mdl_cnt == D);
      check("s_almost_full", s_af, mdl_cnt >= 6);
      check("s_almost_empty", s_ae, mdl_cnt <= 2);
      check("s_overflow", s_ovf, exp_o);
      check("s_underflow", s_udf, exp_u);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset held for two edges
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_empty", s_empty, 1);
      check("rst_almost_empty", s_ae, 1);
      check("rst_full", s_full, 0);
      check("rst_count", s_count, 0);
      check("rst_valid", s_valid, 0);
      check("rst_rdata", s_rdata, 0);
      check("rst_ovf", s_ovf, 0);
      check("rst_f_empty", f_empty, 1);
      check("rst_f_valid", f_valid, 0);
      check("rst_f_rdata", f_rdata, 0);
      rst_n = 1'b1;
      tick_std();

      // fill 1..9: almost_full at 6, full at 8, overflow on 9th
      for (int v = 1; v <= 9; v++) begin
         s_wr = 1'b1;
         s_wdata = DW'(v);
         tick_std();
      end
      s_wr = 1'b0;
      tick_std();

      // drain with 9 back-to-back reads: 1..8 then underflow
      s_rd = 1'b1;
      for (int i = 0; i < 9; i++) tick_std();
      s_rd = 1'b0;
      tick_std();

      // count=4, then 16 simultaneous rd+wr across pointer wrap, then drain
      s_wr = 1'b1;
      for (int v = 1; v <= 4; v++) begin
         s_wdata = DW'(v);
         tick_std();
      end
      s_rd = 1'b1;
      for (int v = 5; v <= 20; v++) begin
         s_wdata = DW'(v);
         tick_std();
      end
      s_wr = 1'b0;
      for (int i = 0; i < 4; i++) tick_std();
      s_rd = 1'b0;
      tick_std();

      // full + simultaneous rd/wr: read accepted, write rejected
      s_wr = 1'b1;
      for (int i = 0; i < D; i++) begin
         s_wdata = DW'(8'h30 + i);
         tick_std();
      end
      s_rd = 1'b1;
      s_wdata = 8'hEE;
      tick_std();
      check("full_rdwr_count", s_count, 7);
      check("full_rdwr_ovf", s_ovf, 1);

      // flush with wr/rd asserted: ignored, no pulses, rdata retained
      s_flush = 1'b1;
      tick_std();
      s_flush = 1'b0;
      s_wr = 1'b0;
      s_rd = 1'b0;
      tick_std();

      // FWFT: first word visible without rd
      f_wr = 1'b1;
      f_wdata = 8'hA5;
      tick();
      f_wr = 1'b0;
      check("fwft_first_valid", f_valid, 1);
      check("fwft_first_rdata", f_rdata, 8'hA5);
      check("fwft_first_count", f_count, 1);
      f_rd = 1'b1;
      tick();
      f_rd = 1'b0;
      check("fwft_pop_empty", f_empty, 1);
      check("fwft_pop_valid", f_valid, 0);

      // FWFT: next word appears with the count update
      f_wr = 1'b1;
      f_wdata = 8'h11;
      tick();
      f_wdata = 8'h22;
      tick();
      f_wr = 1'b0;
      check("fwft_head0", f_rdata, 8'h11);
      f_rd = 1'b1;
      tick();
      f_rd = 1'b0;
      check("fwft_head1", f_rdata, 8'h22);
      check("fwft_head1_count", f_count, 1);
      f_rd = 1'b1;
      tick();
      f_rd = 1'b0;
      check("fwft_drained", f_empty, 1);

      // FWFT: flush at count=5 with wr held
      f_wr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         f_wdata = DW'(8'h40 + i);
         tick();
      end
      check("fwft_count5", f_count, 5);
      f_flush = 1'b1;
      tick();
      f_flush = 1'b0;
      f_wr = 1'b0;
      check("fwft_flush_count", f_count, 0);
      check("fwft_flush_ovf", f_ovf, 0);
      check("fwft_flush_udf", f_udf, 0);
      check("fwft_flush_valid", f_valid, 0);
      check("fwft_flush_ae", f_ae, 1);
      check("fwft_flush_af", f_af, 0);
      check("fwft_flush_full", f_full, 0);
      tick();
      check("fwft_post_flush_ovf", f_ovf, 0);
      check("fwft_post_flush_empty", f_empty, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
